button_led_ctrl: RTL
====================

# button_led_ctrl

Parametrised N-channel button-to-LED controller. Each raw pushbutton is synchronised, debounced and edge-detected, then drives its LED in one of four global modes: follow, toggle, blink or off. It sits between board pushbuttons and LED pins and replaces the direct combinational button-to-LED path with clocked, glitch-free behaviour plus per-channel press/release event pulses for other logic.

## Interface
- N_CH, 5: number of button/LED channels (≥1).
- DB_CYCLES, 50000: consecutive stable cycles required to accept a new button level (≥1).
- BLINK_HALF, 6000000: blink half-period in cycles (≥1).
- ACTIVE_LOW_BTN, 0: 1 = raw button reads 0 when pressed; inversion is applied after synchronisation.
- CLK  in  1  sole clock, all state rising-edge.
- RST_N  in  1  reset, asynchronous assert, active-low; one clock, reset asynchronous and active-low.
- BUTTON  in  N_CH  raw asynchronous button levels.
- MODE  in  2  global LED mode: 00 follow, 01 toggle, 10 blink, 11 off.
- LED  out  N_CH  registered LED drive, 1 = on.
- PRESS  out  N_CH  one-cycle pulse per accepted press.
- RELEASE  out  N_CH  one-cycle pulse per accepted release.

## Operation
- Per channel, independent: 2-flop synchroniser (reset 0), then optional inversion, giving s.
- Debounce: stable level db (reset 0), counter cnt of width clog2(DB_CYCLES+1) (reset 0).
  - s == db: cnt <= 0.
  - s != db and cnt < DB_CYCLES-1: cnt <= cnt+1.
  - s != db and cnt == DB_CYCLES-1: db <= s, cnt <= 0.
  - Any single cycle of s == db during counting restarts the count (bounce rejection).
- Events, registered on the same edge that updates db: PRESS[i] <= (db 0→1), RELEASE[i] <= (db 1→0). Each is high exactly one cycle; otherwise 0.
- Toggle state tgl (reset 0) flips on every PRESS in all modes; MODE never alters tgl.
- Shared blink counter bcnt 0..BLINK_HALF-1 (reset 0), free-running, wraps; phase bit (reset 0) inverts on each wrap.
- LED[i] registered: MODE 00 → db; 01 → tgl; 10 → tgl & phase; 11 → 0.
- MODE is sampled every cycle; a change takes effect on the LED one edge later. No MODE synchroniser; MODE is assumed synchronous to CLK.
- Reset assertion clears synchronisers, db, cnt, tgl, bcnt, phase and all outputs immediately, without a clock edge. After deassertion, a held button requires the full sync + debounce latency before acceptance.
- Simultaneous presses on several channels produce simultaneous independent PRESS pulses.

## Timing
- Reset values: LED = 0, PRESS = 0, RELEASE = 0.
- Raw level first sampled at edge 0 → s valid after edge 1 → db and PRESS/RELEASE update at edge DB_CYCLES+1 → LED (modes 00/01) updates at edge DB_CYCLES+2.
- PRESS/RELEASE pulse width: exactly 1 cycle. Minimum spacing between opposite events on a channel: DB_CYCLES cycles.
- Blink: phase period = 2·BLINK_HALF cycles. LED follows phase one edge later.
- The same latency applies symmetrically to releases.

## Test plan
- Bench config: N_CH=2, DB_CYCLES=4, BLINK_HALF=8, ACTIVE_LOW_BTN=0.
- Reset hold: RST_N=0, BUTTON=2'b11, MODE=00 for 20 cycles → LED=00, PRESS=00, RELEASE=00 throughout. Deassert → LED rises only at edge 6 after deassertion.
- Clean press/release, MODE=00: BUTTON[0] 0→1 sampled at edge 0 → PRESS[0]=1 for exactly the cycle after edge 5, LED[0]=1 after edge 6. Release gives the mirrored RELEASE[0] pulse and LED[0]=0 at the same offsets. Channel 1 stays 0.
- Bounce: BUTTON[0] high 3 cycles, low 1, high 3, low → no PRESS, LED[0]=0. Then high ≥6 cycles → a single PRESS.
- Toggle, MODE=01: two clean presses on ch0 plus a simultaneous press on ch1 → LED[0] goes 1 then 0, LED[1]=1, PRESS[1] coincides with ch0's first PRESS.
- Blink/off, tgl[0]=1: MODE=10 → LED[0] toggles every 8 cycles. MODE=11 → LED[0]=0 next edge. MODE=01 → LED[0]=1, with tgl preserved.
- Async reset mid-debounce (cnt=2) with tgl=1 and LED=1: pulse RST_N low between edges → LED and tgl are 0 immediately, and no PRESS follows until a full 6-edge acceptance.

Source files
------------

// File: rtl/button_led_ctrl.sv
// N-channel pushbutton front end: 2-flop synchroniser, debounce, press/release
// events, and a registered LED driver with follow/toggle/blink/off modes.
module button_led_ctrl #(
  parameter int N_CH           = 5,
  parameter int DB_CYCLES      = 50000,
  parameter int BLINK_HALF     = 6000000,
  parameter int ACTIVE_LOW_BTN = 0
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic [N_CH-1:0] BUTTON,
  input  logic [1:0]      MODE,
  output logic [N_CH-1:0] LED,
  output logic [N_CH-1:0] PRESS,
  output logic [N_CH-1:0] RELEASE
);

  localparam int CW = (DB_CYCLES > 0) ? $clog2(DB_CYCLES + 1) : 1;
  localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(DB_CYCLES - 1);
  localparam logic [BW-1:0] BCNT_LAST = BW'(BLINK_HALF - 1);

  typedef enum logic [1:0] {
    MODE_FOLLOW = 2'b00,
    MODE_TOGGLE = 2'b01,
    MODE_BLINK  = 2'b10,
    MODE_OFF    = 2'b11
  } mode_e;

  logic [N_CH-1:0] sync_p0;
  logic [N_CH-1:0] sync_p1;
  logic [N_CH-1:0] s_p1;

  logic [N_CH-1:0] db;
  logic [N_CH-1:0] db_nxt;
  logic [CW-1:0]   cnt     [N_CH];
  logic [CW-1:0]   cnt_nxt [N_CH];
  logic [N_CH-1:0] press_nxt;
  logic [N_CH-1:0] release_nxt;
  logic [N_CH-1:0] tgl;
  logic [N_CH-1:0] tgl_nxt;

  logic [BW-1:0]   bcnt;
  logic [BW-1:0]   bcnt_nxt;
  logic            phase;
  logic            phase_nxt;
  logic            bwrap;

  logic [N_CH-1:0] led_nxt;

  // Stage p0/p1: metastability synchroniser; polarity fixed after the second flop
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= BUTTON;
      sync_p1 <= sync_p0;
    end
  end

  assign s_p1 = sync_p1 ^ {N_CH{ACTIVE_LOW_BTN != 0}};

  // Debounce stage: a level is accepted only after DB_CYCLES consecutive disagreeing samples
  always_comb begin
    db_nxt      = db;
    cnt_nxt     = cnt;
    press_nxt   = '0;
    release_nxt = '0;
    tgl_nxt     = tgl;
    for (int i = 0; i < N_CH; i++) begin
      if (s_p1[i] == db[i]) begin
        cnt_nxt[i] = '0;
      end else if (cnt[i] == CNT_LAST) begin
        db_nxt[i]      = s_p1[i];
        cnt_nxt[i]     = '0;
        press_nxt[i]   = s_p1[i];
        release_nxt[i] = ~s_p1[i];
        tgl_nxt[i]     = tgl[i] ^ s_p1[i];
      end else begin
        cnt_nxt[i] = cnt[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      db      <= '0;
      tgl     <= '0;
      PRESS   <= '0;
      RELEASE <= '0;
      for (int i = 0; i < N_CH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      db      <= db_nxt;
      tgl     <= tgl_nxt;
      PRESS   <= press_nxt;
      RELEASE <= release_nxt;
      for (int i = 0; i < N_CH; i++) begin
        cnt[i] <= cnt_nxt[i];
      end
    end
  end

  // Blink timebase, shared by all channels
  always_comb begin
    bwrap     = (bcnt == BCNT_LAST);
    bcnt_nxt  = bwrap ? '0 : bcnt + 1'b1;
    phase_nxt = phase ^ bwrap;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      bcnt  <= '0;
      phase <= 1'b0;
    end else begin
      bcnt  <= bcnt_nxt;
      phase <= phase_nxt;
    end
  end

  // Output stage: LED is registered so a MODE change lands one edge later
  always_comb begin
    led_nxt = '0;
    case (mode_e'(MODE))
      MODE_FOLLOW: led_nxt = db;
      MODE_TOGGLE: led_nxt = tgl;
      MODE_BLINK:  led_nxt = tgl & {N_CH{phase}};
      MODE_OFF:    led_nxt = '0;
      default:     led_nxt = '0;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      LED <= '0;
    end else begin
      LED <= led_nxt;
    end
  end

endmodule
